// File: rtl/pong_pkg.sv
// Shared Pong definitions: match state encodings, winner codes and default timing
// constants used by the match controller, ball and score display.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SERVE  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_PAUSED = 3'd3,
    ST_GOAL   = 3'd4,
    ST_OVER   = 3'd5
  } state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam int unsigned DEF_SERVE_FRAMES = 120;
  localparam int unsigned DEF_GOAL_FRAMES  = 60;
  localparam int unsigned DEF_WIN_SCORE    = 5;

endpackage

// File: rtl/match_ctrl_edge_detect.sv
// One-bit rising-edge detector: a single history flop, edge reported combinationally
// in the cycle the input is first seen high.
module edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_in,
  output logic o_rise
);

  logic prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) prev <= 1'b0;
    else       prev <= i_in;
  end

  assign o_rise = i_in & ~prev;

endmodule

// File: rtl/match_ctrl.sv
// Pong match sequencer: serve/goal frame timing, scoring, pause and winner detection.
// Drives the ball's animate enable and centre-reset pulse; all outputs registered.
module match_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int unsigned GOAL_FRAMES  = DEF_GOAL_FRAMES,
  parameter int unsigned WIN_SCORE    = DEF_WIN_SCORE,
  parameter int unsigned CNT_W        = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ani_stb,
  input  logic       i_start,
  input  logic       i_pause,
  input  logic       i_goal_p1,
  input  logic       i_goal_p2,
  output logic       o_animate,
  output logic       o_ball_rst,
  output logic [3:0] o_score_p1,
  output logic [3:0] o_score_p2,
  output logic [1:0] o_winner,
  output logic [2:0] o_state
);

  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] GOAL_LAST  = CNT_W'(GOAL_FRAMES - 1);
  localparam logic [3:0]       WIN_PTS    = 4'(WIN_SCORE);

  logic start_rise, pause_rise, goal1_rise, goal2_rise;

  edge_detect u_ed_start (.i_clk(i_clk), .i_rst(i_rst), .i_in(i_start),   .o_rise(start_rise));
  edge_detect u_ed_pause (.i_clk(i_clk), .i_rst(i_rst), .i_in(i_pause),   .o_rise(pause_rise));
  edge_detect u_ed_goal1 (.i_clk(i_clk), .i_rst(i_rst), .i_in(i_goal_p1), .o_rise(goal1_rise));
  edge_detect u_ed_goal2 (.i_clk(i_clk), .i_rst(i_rst), .i_in(i_goal_p2), .o_rise(goal2_rise));

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       s1_q, s1_d, s2_q, s2_d;
  logic [1:0]       win_q, win_d;
  logic             anim_q, anim_d, brst_q, brst_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    win_d   = win_q;
    brst_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_rise) begin
          s1_d    = '0;
          s2_d    = '0;
          win_d   = WIN_NONE;
          brst_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (i_ani_stb) begin
          if (cnt_q == SERVE_LAST) begin
            cnt_d   = '0;
            state_d = ST_PLAY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_PLAY: begin
        // p1 goal outranks p2 goal, and any goal outranks a simultaneous pause
        if (goal1_rise) begin
          s1_d    = s1_q + 4'd1;
          cnt_d   = '0;
          state_d = ST_GOAL;
        end else if (goal2_rise) begin
          s2_d    = s2_q + 4'd1;
          cnt_d   = '0;
          state_d = ST_GOAL;
        end else if (pause_rise) begin
          state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (pause_rise) state_d = ST_PLAY;
      end
      ST_GOAL: begin
        if (i_ani_stb) begin
          if (cnt_q == GOAL_LAST) begin
            if (s1_q == WIN_PTS) begin
              win_d   = WIN_P1;
              state_d = ST_OVER;
            end else if (s2_q == WIN_PTS) begin
              win_d   = WIN_P2;
              state_d = ST_OVER;
            end else begin
              brst_d  = 1'b1;
              cnt_d   = '0;
              state_d = ST_SERVE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    anim_d = (state_d == ST_PLAY);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      win_q   <= WIN_NONE;
      anim_q  <= 1'b0;
      brst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      win_q   <= win_d;
      anim_q  <= anim_d;
      brst_q  <= brst_d;
    end
  end

  assign o_state    = state_q;
  assign o_animate  = anim_q;
  assign o_ball_rst = brst_q;
  assign o_score_p1 = s1_q;
  assign o_score_p2 = s2_q;
  assign o_winner   = win_q;

endmodule

// File: tb/tb_match_ctrl.sv
// Scoreboard bench for match_ctrl: every expected output change is queued with the
// cycle it must appear on; a monitor pops and compares whenever the outputs change.
module tb_match_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stb = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       g1 = 1'b0;
  logic       g2 = 1'b0;
  logic       o_animate, o_ball_rst;
  logic [3:0] o_score_p1, o_score_p2;
  logic [1:0] o_winner;
  logic [2:0] o_state;

  match_ctrl #(
    .SERVE_FRAMES(4),
    .GOAL_FRAMES (3),
    .WIN_SCORE   (2),
    .CNT_W       (8)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_ani_stb (stb),
    .i_start   (start),
    .i_pause   (pause),
    .i_goal_p1 (g1),
    .i_goal_p2 (g2),
    .o_animate (o_animate),
    .o_ball_rst(o_ball_rst),
    .o_score_p1(o_score_p1),
    .o_score_p2(o_score_p2),
    .o_winner  (o_winner),
    .o_state   (o_state)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int unsigned cyc;
    logic [14:0] v;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // {state, animate, ball_rst, score_p1, score_p2, winner}
  function automatic logic [14:0] pk(input int st, input int an, input int br,
                                     input int a, input int b, input int w);
    return {3'(st), 1'(an), 1'(br), 4'(a), 4'(b), 2'(w)};
  endfunction

  task automatic expect_at(input int unsigned c, input logic [14:0] v);
    exp_t e;
    e.cyc = c;
    e.v   = v;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame: three quiet cycles then a strobe; up to two changes expected from the strobe
  task automatic frame(input int n_exp, input logic [14:0] v1, input logic [14:0] v2);
    repeat (3) tick();
    stb = 1'b1;
    if (n_exp >= 1) expect_at(cyc + 1, v1);
    if (n_exp >= 2) expect_at(cyc + 2, v2);
    tick();
    stb = 1'b0;
  endtask

  task automatic serve(input logic [14:0] v_play);
    repeat (3) frame(0, '0, '0);
    frame(1, v_play, '0);
  endtask

  task automatic goal_hold(input int n_exp, input logic [14:0] v1, input logic [14:0] v2);
    repeat (2) frame(0, '0, '0);
    frame(n_exp, v1, v2);
  endtask

  task automatic press_start(input int a, input int b);
    start = 1'b1;
    expect_at(cyc + 1, pk(1, 0, 1, a, b, 0));
    expect_at(cyc + 2, pk(1, 0, 0, a, b, 0));
    tick();
    start = 1'b0;
  endtask

  initial begin : monitor
    logic [14:0] prev, cur;
    exp_t        e;
    prev = '1;
    forever begin
      @(negedge clk);
      cur = {o_state, o_animate, o_ball_rst, o_score_p1, o_score_p2, o_winner};
      if (cur !== prev) begin
        n_assert++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change: cycle %0d outputs %h, none expected", cyc, cur);
        end else begin
          e = q.pop_front();
          if (e.v !== cur || e.cyc != cyc) begin
            n_fail++;
            $display("FAIL out_change: cycle %0d outputs %h, required cycle %0d outputs %h",
                     cyc, cur, e.cyc, e.v);
          end
        end
        prev = cur;
      end else if (q.size() != 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        n_assert++;
        n_fail++;
        $display("FAIL missing_change: by cycle %0d outputs still %h, required cycle %0d outputs %h",
                 cyc, cur, e.cyc, e.v);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    expect_at(1, pk(0, 0, 0, 0, 0, 0));
    repeat (3) tick();
    rst = 1'b0;
    tick();

    press_start(0, 0);
    serve(pk(2, 1, 0, 0, 0, 0));

    // p2 goal flag held high through the goal pause: single increment
    g2 = 1'b1;
    expect_at(cyc + 1, pk(4, 0, 0, 0, 1, 0));
    tick();
    goal_hold(2, pk(1, 0, 1, 0, 1, 0), pk(1, 0, 0, 0, 1, 0));
    g2 = 1'b0;
    serve(pk(2, 1, 0, 0, 1, 0));

    // pause, goal and start while paused are ignored, resume without ball reset
    pause = 1'b1;
    expect_at(cyc + 1, pk(3, 0, 0, 0, 1, 0));
    tick();
    pause = 1'b0;
    tick();
    g1 = 1'b1;
    frame(0, '0, '0);
    g1 = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    frame(0, '0, '0);
    pause = 1'b1;
    expect_at(cyc + 1, pk(2, 1, 0, 0, 1, 0));
    tick();
    pause = 1'b0;
    tick();

    // simultaneous goals: p1 only
    g1 = 1'b1;
    g2 = 1'b1;
    expect_at(cyc + 1, pk(4, 0, 0, 1, 1, 0));
    tick();
    frame(0, '0, '0);

    // reset mid-goal at 1/1, then a start edge is needed to leave IDLE
    rst = 1'b1;
    expect_at(cyc + 1, pk(0, 0, 0, 0, 0, 0));
    tick();
    rst = 1'b0;
    g1 = 1'b0;
    g2 = 1'b0;
    repeat (3) frame(0, '0, '0);
    press_start(0, 0);
    serve(pk(2, 1, 0, 0, 0, 0));

    // p1 wins 2-0
    g1 = 1'b1;
    expect_at(cyc + 1, pk(4, 0, 0, 1, 0, 0));
    tick();
    goal_hold(2, pk(1, 0, 1, 1, 0, 0), pk(1, 0, 0, 1, 0, 0));
    g1 = 1'b0;
    serve(pk(2, 1, 0, 1, 0, 0));
    g1 = 1'b1;
    expect_at(cyc + 1, pk(4, 0, 0, 2, 0, 0));
    tick();
    goal_hold(1, pk(5, 0, 0, 2, 0, 1), '0);
    g1 = 1'b0;
    tick();
    g1 = 1'b1;
    tick();
    g1 = 1'b0;
    g2 = 1'b1;
    pause = 1'b1;
    tick();
    g2 = 1'b0;
    pause = 1'b0;
    frame(0, '0, '0);
    press_start(0, 0);
    serve(pk(2, 1, 0, 0, 0, 0));

    // goal together with pause: goal taken, pause dropped; then p2 wins 0-2
    g2 = 1'b1;
    pause = 1'b1;
    expect_at(cyc + 1, pk(4, 0, 0, 0, 1, 0));
    tick();
    pause = 1'b0;
    goal_hold(2, pk(1, 0, 1, 0, 1, 0), pk(1, 0, 0, 0, 1, 0));
    g2 = 1'b0;
    serve(pk(2, 1, 0, 0, 1, 0));
    g2 = 1'b1;
    expect_at(cyc + 1, pk(4, 0, 0, 0, 2, 0));
    tick();
    goal_hold(1, pk(5, 0, 0, 0, 2, 2), '0);
    g2 = 1'b0;
    repeat (6) tick();

    n_assert++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d expected changes outstanding, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
